// File: rtl/brain_m_pkg.sv
// Shared constants, shape-code layout and FSM encoding for the brain memory neurons
// (recall_neuron and inter_neuron).
package brain_m_pkg;

  localparam int DEPTH   = 20;
  localparam int TH_MAX  = 100;
  localparam int TH_STEP = 5;

  // Shape code is {flat, addr}: the low field tags each entry with its own address.
  localparam int FLAT_W = 7;
  localparam int ADDR_W = 5;
  localparam int CODE_W = FLAT_W + ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_CMP  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic [FLAT_W-1:0] code_flat(input logic [CODE_W-1:0] code);
    return code[CODE_W-1:ADDR_W];
  endfunction

  function automatic logic [ADDR_W-1:0] code_addr(input logic [CODE_W-1:0] code);
    return code[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/shape_match.sv
// Combinational hit test for one memory entry: flat value and address tag must both
// agree, and a zero query never matches so blank entries cannot alias.
module shape_match
  import brain_m_pkg::*;
(
  input  logic [CODE_W-1:0] rData,
  input  logic [FLAT_W-1:0] qReg,
  input  logic [ADDR_W-1:0] addr,
  output logic              hit
);

  assign hit = (code_flat(rData) == qReg) &&
               (code_addr(rData) == addr) &&
               (qReg != '0);

endmodule

// File: rtl/recall_neuron.sv
// Recall neuron: scans the shape memory from address 0 upward for the captured query
// and reports the first tagged match together with its recovered threshold.
module recall_neuron
  import brain_m_pkg::*;
#(
  parameter int DEPTH   = brain_m_pkg::DEPTH,
  parameter int TH_MAX  = brain_m_pkg::TH_MAX,
  parameter int TH_STEP = brain_m_pkg::TH_STEP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [6:0]  flat,
  output logic        rE,
  output logic [4:0]  rAddr,
  input  logic [11:0] rData,
  output logic        busy,
  output logic        done,
  output logic        match,
  output logic [4:0]  matchAddr,
  output logic [6:0]  thOut
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  function automatic logic [FLAT_W-1:0] th_of(input logic [ADDR_W-1:0] a);
    return FLAT_W'(16'(TH_MAX) - 16'(TH_STEP) * 16'(a));
  endfunction

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [FLAT_W-1:0]   qreg_q, qreg_d;
  logic                match_q, match_d;
  logic [ADDR_W-1:0]   match_addr_q, match_addr_d;
  logic [FLAT_W-1:0]   th_q, th_d;
  logic                hit;

  shape_match u_shape_match (
    .rData (rData),
    .qReg  (qreg_q),
    .addr  (addr_q),
    .hit   (hit)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    qreg_d       = qreg_q;
    match_d      = match_q;
    match_addr_d = match_addr_q;
    th_d         = th_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          qreg_d  = flat;
          addr_d  = '0;
          state_d = ST_READ;
        end
      end
      ST_READ: state_d = ST_CMP;
      // rData now reflects the address issued in READ
      ST_CMP: begin
        if (hit) begin
          match_d      = 1'b1;
          match_addr_d = addr_q;
          th_d         = th_of(addr_q);
          state_d      = ST_DONE;
        end else if (addr_q == LAST_ADDR) begin
          match_d      = 1'b0;
          match_addr_d = '0;
          th_d         = '0;
          state_d      = ST_DONE;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = ST_READ;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      qreg_q       <= '0;
      match_q      <= 1'b0;
      match_addr_q <= '0;
      th_q         <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      qreg_q       <= qreg_d;
      match_q      <= match_d;
      match_addr_q <= match_addr_d;
      th_q         <= th_d;
    end
  end

  // The address counter only moves on the way into READ, so rAddr naturally holds.
  assign rE        = (state_q == ST_READ);
  assign rAddr     = addr_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign match     = match_q;
  assign matchAddr = match_addr_q;
  assign thOut     = th_q;

endmodule

// File: tb/tb_recall_neuron.sv
// Scoreboard bench for recall_neuron: directed scans push expected results, a
// done-driven monitor pops and compares them, including the done cycle.
module tb_recall_neuron;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [6:0]  flat;
  logic        rE;
  logic [4:0]  rAddr;
  logic [11:0] rData = '0;
  logic        busy;
  logic        done;
  logic        match;
  logic [4:0]  matchAddr;
  logic [6:0]  thOut;

  logic [11:0] mem [32];
  int          ecnt = 0;
  int          checks = 0;
  int          failures = 0;
  logic        prev_done = 1'b0;

  typedef struct {
    int         s;
    logic       m;
    logic [4:0] a;
    logic [6:0] th;
    int         cyc;
  } exp_t;

  exp_t sb[$];

  recall_neuron dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .flat      (flat),
    .rE        (rE),
    .rAddr     (rAddr),
    .rData     (rData),
    .busy      (busy),
    .done      (done),
    .match     (match),
    .matchAddr (matchAddr),
    .thOut     (thOut)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ecnt <= ecnt + 1;
    if (rE) rData <= mem[rAddr];
  end

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endfunction

  // Monitor: every done pulse must correspond to a queued expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      chk("done_one_cycle", int'(prev_done), 0);
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_cycle", ecnt - e.s, e.cyc);
        chk("match", int'(match), int'(e.m));
        chk("matchAddr", int'(matchAddr), int'(e.a));
        chk("thOut", int'(thOut), int'(e.th));
      end
    end
    prev_done = done;
  end

  task automatic clear_mem();
    for (int i = 0; i < 32; i++) mem[i] = '0;
  endtask

  task automatic run_scan(input logic [6:0] f, input logic m, input logic [4:0] a,
                          input logic [6:0] th, input int cyc);
    int n;
    @(negedge clk);
    flat  = f;
    start = 1'b1;
    sb.push_back('{ecnt, m, a, th, cyc});
    @(negedge clk);
    start = 1'b0;
    flat  = 7'd0;
    chk("cycle1_rE", int'(rE), 1);
    chk("cycle1_rAddr", int'(rAddr), 0);
    chk("cycle1_busy", int'(busy), 1);
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("scan_timeout_pending", sb.size(), 0);
      sb.delete();
    end
    @(negedge clk);
    chk("idle_busy", int'(busy), 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_rE"}, int'(rE), 0);
    chk({tag, "_rAddr"}, int'(rAddr), 0);
    chk({tag, "_match"}, int'(match), 0);
    chk({tag, "_matchAddr"}, int'(matchAddr), 0);
    chk({tag, "_thOut"}, int'(thOut), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int s;
    rst   = 1'b1;
    start = 1'b0;
    flat  = 7'd0;
    clear_mem();
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    // Single tagged entry at address 3
    mem[3] = {7'd85, 5'd3};
    run_scan(7'd85, 1'b1, 5'd3, 7'd85, 9);

    // Blank memory: nonzero and zero queries both miss
    clear_mem();
    run_scan(7'd50, 1'b0, 5'd0, 7'd0, 41);
    run_scan(7'd0, 1'b0, 5'd0, 7'd0, 41);

    // Duplicate entries: lowest address wins
    mem[2] = {7'd90, 5'd2};
    mem[7] = {7'd90, 5'd7};
    run_scan(7'd90, 1'b1, 5'd2, 7'd90, 7);

    // Ignored restart, then reset mid-scan with no done pulse
    clear_mem();
    mem[3]  = {7'd85, 5'd3};
    mem[19] = {7'd5, 5'd19};
    @(negedge clk);
    flat  = 7'd5;
    start = 1'b1;
    s = ecnt;
    sb.push_back('{s, 1'b1, 5'd19, 7'd5, 41});
    @(negedge clk);
    start = 1'b0;
    flat  = 7'd0;
    while (ecnt - s < 3) @(negedge clk);
    start = 1'b1;
    flat  = 7'd85;
    @(negedge clk);
    start = 1'b0;
    flat  = 7'd0;
    chk("restart_ignored_busy", int'(busy), 1);
    while (ecnt - s < 10) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    check_zero("midscan_rst");
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("post_rst_idle_busy", int'(busy), 0);

    // Fresh scan after reset, hit at the last address
    run_scan(7'd5, 1'b1, 5'd19, 7'd5, 41);

    // Bad address tag must not match
    clear_mem();
    mem[5] = {7'd75, 5'd6};
    run_scan(7'd75, 1'b0, 5'd0, 7'd0, 41);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/recall_neuron.md
RECALL_NEURON -- requirements
Module: recall_neuron

Interface
REQ-001 SHALL have parameter DEPTH, default 20, number of memory neuron entries scanned (addresses 0..DEPTH-1).
REQ-002 SHALL have parameter TH_MAX, default 100, threshold stored at address 0.
REQ-003 SHALL have parameter TH_STEP, default 5, threshold decrement per address.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-006 SHALL have port start  input  1  recall request, sampled only in IDLE.
REQ-007 SHALL have port flat  input  7  query flat value, captured with start.
REQ-008 SHALL have port rE  output  1  memory read enable.
REQ-009 SHALL have port rAddr  output  5  memory read address.
REQ-010 SHALL have port rData  input  12  shape code read back; {flat[6:0], addr[4:0]}; valid one cycle after rE.
REQ-011 SHALL have port busy  output  1  scan in progress.
REQ-012 SHALL have port done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port match  output  1  query found.
REQ-014 SHALL have port matchAddr  output  5  address of first matching entry.
REQ-015 SHALL have port thOut  output  7  recovered threshold = TH_MAX - TH_STEP*matchAddr.

Function
REQ-016 SHALL implement states IDLE, READ, CMP, DONE.
REQ-017 IDLE: start=1 -> capture flat into qReg, clear addr counter to 0, go READ; start=0 -> stay.
REQ-018 READ: rE=1, rAddr=addr counter; go CMP.
REQ-019 CMP: hit = (rData[11:5]==qReg) AND (rData[4:0]==addr) AND (qReg!=0); the tag check rejects unwritten or zero entries.
REQ-020 CMP hit: register match=1, matchAddr=addr, thOut=TH_MAX-TH_STEP*addr; go DONE.
REQ-021 CMP miss with addr==DEPTH-1: register match=0, matchAddr=0, thOut=0; go DONE.
REQ-022 CMP miss otherwise: addr+1, go READ.
REQ-023 DONE: done=1 for exactly one cycle; go IDLE.
REQ-024 busy SHALL be 1 in READ, CMP and DONE, and 0 in IDLE.
REQ-025 rE SHALL be 0 outside READ; rAddr SHALL hold its last value.
REQ-026 Latency: start sampled at edge 0; a hit at address k drives done high in cycle 3+2k; a full miss drives done high in cycle 3+2*(DEPTH-1), i.e. cycle 41 at the default.
REQ-027 match, matchAddr and thOut SHALL hold their values until the next CMP terminal decision; they are not cleared by start.
REQ-028 start while busy SHALL be ignored; flat changes after capture SHALL not affect the scan.
REQ-029 Duplicate matching entries SHALL report the lowest address.
REQ-030 thOut arithmetic SHALL be unsigned 7-bit; at the defaults it is never negative (min 5).
REQ-031 rst asserted mid-scan SHALL abort immediately with no done pulse.

Reset
REQ-032 On rst: state=IDLE, addr=0, qReg=0, rE=0, rAddr=0, busy=0, done=0, match=0, matchAddr=0, thOut=0.

Structure
REQ-033 DEPTH, TH_MAX, TH_STEP, the 12-bit shape-code field split, and the state encoding SHALL live in shared package brain_m_pkg, also used by inter_neuron.
REQ-034 The hit compare (REQ-019) SHALL be sub-module shape_match: combinational, with inputs rData, qReg, addr and output hit.

Verification
REQ-035 Memory model with entry 3 = {7'd85, 5'd3}; start with flat=85 -> done in cycle 9, match=1, matchAddr=3, thOut=85.
REQ-036 All entries 0 (unwritten); start with flat=50 -> done in cycle 41, match=0; start with flat=0 -> match=0.
REQ-037 Entries 2 and 7 both hold flat=90 with correct tags -> matchAddr=2, thOut=90.
REQ-038 Entry 5 = {7'd75, 5'd6} (bad tag); query 75 -> match=0.
REQ-039 start pulsed again during a scan and rst asserted at cycle 10 -> second start ignored; after rst all outputs 0 with no done pulse; a new start then completes normally.
REQ-040 Hit at entry 19 = {7'd5, 5'd19} -> done in cycle 41, thOut=5.
